ext_int_cont: RTL and testbench
===============================

EXT_INT_CONT -- requirements
Module: ext_int_cont

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth on each irq line; legal values 2 or 3.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_b  input  1  reset, asynchronous, active-low.
REQ-004 irq  input  16  external interrupt lines, asynchronous; bit i is source i; rising-edge sensitive.
REQ-005 int_en  input  1  global dispatch enable.
REQ-006 halt  input  1  processor halt; blocks dispatch.
REQ-007 mask_we  input  1  write strobe for the enable-mask register.
REQ-008 mask_wdata  input  16  mask write data; 1 = source enabled.
REQ-009 pend_clr_we  input  1  software pending-clear strobe.
REQ-010 pend_clr_data  input  16  write-1-to-clear pending bits.
REQ-011 int_rdy  input  1  downstream controller ready to accept a request.
REQ-012 int_srv_req  input  1  downstream controller is servicing an interrupt.
REQ-013 int_srv_num  input  16  number being serviced downstream.
REQ-014 int_req  output  1  single-cycle interrupt request, registered.
REQ-015 int_num  output  16  dispatched source index, zero-extended; held until the next dispatch.
REQ-016 pending  output  16  pending register.
REQ-017 mask  output  16  mask register.
REQ-018 in_service  output  16  one-hot source currently in service, or 0.
REQ-019 srv_err  output  1  sticky service-number mismatch flag.

Function
REQ-020 Each irq bit passes through SYNC_STAGES flops, then a rising-edge detector (synchronized value 1, previous value 0).
REQ-021 A detected edge sets its pending bit regardless of mask; mask gates dispatch only.
REQ-022 pend_clr_we clears the pending bits set in pend_clr_data; an edge on the same bit in the same cycle wins, and the bit stays set.
REQ-023 mask_we loads mask_wdata on the next edge; the new mask takes effect for dispatch decisions from the following cycle.
REQ-024 Eligible set = pending & mask; priority is the lowest index first (source 0 highest).
REQ-025 The FSM has 3 states: IDLE, WAIT_SRV and WAIT_DONE; an unused encoding goes to IDLE.
REQ-026 Dispatch rule in IDLE: when int_rdy=1, halt=0, int_en=1 and eligible≠0:
- int_req=1 for exactly one cycle;
- int_num is loaded with the winning index;
- the winner's pending bit is cleared, unless a new edge arrives on it that cycle;
- the winner's in_service bit is set;
- the FSM goes to WAIT_SRV.
REQ-027 WAIT_SRV: int_req=0; move to WAIT_DONE on the first cycle int_srv_req=1; there is no timeout, and the FSM waits indefinitely, including across halt.
REQ-028 On the cycle of the WAIT_SRV→WAIT_DONE transition, if int_srv_num≠int_num, set srv_err; only reset clears it.
REQ-029 WAIT_DONE: when int_srv_req=0, clear in_service and go to IDLE; no dispatch on that same cycle.
REQ-030 At most one request is outstanding; edges arriving during WAIT_SRV or WAIT_DONE accumulate in pending only.
REQ-031 Edges on a source that is in service are still latched into pending.
REQ-032 Dispatch latency: with edge N the first clock edge sampling irq=1, the pending bit is set after edge N+SYNC_STAGES and int_req is high during the cycle after edge N+SYNC_STAGES+1, given the IDLE dispatch conditions hold.
REQ-033 Clearing an eligible bit via mask or pend_clr in the same cycle as dispatch does not cancel the dispatch; the decision uses register values from before the edge.

Reset
REQ-034 reset_b=0 asynchronously forces:
- the FSM to IDLE;
- int_req=0 and int_num=0;
- pending=0, mask=0 and in_service=0;
- srv_err=0;
- all synchronizer and edge-detect flops to 0.
REQ-035 Reset asserted mid-service abandons the in-flight interrupt; after release no request issues until a new edge arrives and the source is unmasked.
REQ-036 An irq line held high through reset release produces one edge, SYNC_STAGES+1 edges after release.

Verification
REQ-037 Single source: mask=0x0001, int_en=1, int_rdy=1, pulse irq[0] -> int_req one cycle at REQ-032 latency, int_num=0x0000, in_service=0x0001, pending=0.
REQ-038 Priority: irq[5] and irq[2] rise together, mask=0xFFFF -> first dispatch int_num=0x0002; after the int_srv_req 1→0 handshake, second dispatch int_num=0x0005.
REQ-039 Masking: irq[7] edge with mask=0x0000 -> pending=0x0080, no int_req; write mask=0x0080 -> dispatch int_num=0x0007.
REQ-040 Blocking: halt=1 or int_rdy=0 with pending eligible -> no int_req; deassert -> int_req on the next cycle.
REQ-041 Mismatch: dispatch int_num=3, return int_srv_req=1 with int_srv_num=4 -> srv_err=1 and sticky until reset.
REQ-042 Boundaries: edge coincident with pend_clr on the same bit -> bit stays set; reset asserted in WAIT_DONE -> all outputs 0 immediately.

Source files
------------

// File: rtl/ext_int_cont.sv
// External interrupt controller: synchronises 16 edge-triggered lines, latches
// them as pending, and dispatches the lowest enabled index with a req/service handshake.
module ext_int_cont #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] irq,
    input  logic        int_en,
    input  logic        halt,
    input  logic        mask_we,
    input  logic [15:0] mask_wdata,
    input  logic        pend_clr_we,
    input  logic [15:0] pend_clr_data,
    input  logic        int_rdy,
    input  logic        int_srv_req,
    input  logic [15:0] int_srv_num,
    output logic        int_req,
    output logic [15:0] int_num,
    output logic [15:0] pending,
    output logic [15:0] mask,
    output logic [15:0] in_service,
    output logic        srv_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SRV  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] prev_q;
    logic [15:0] pend_q, pend_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] insrv_q, insrv_d;
    logic [15:0] num_q, num_d;
    logic        req_q, req_d;
    logic        err_q, err_d;

    logic [15:0] irq_edge;
    logic [15:0] eligible;
    logic [15:0] win_oh;
    logic [3:0]  win_idx;
    logic        found;
    logic        dispatch;

    assign irq_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign eligible = pend_q & mask_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Lowest set index wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (eligible[i] && !found) begin
                found   = 1'b1;
                win_idx = 4'(i);
            end
        end
        win_oh = 16'd1 << win_idx;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = 1'b0;
        num_d    = num_q;
        insrv_d  = insrv_q;
        err_d    = err_q;
        mask_d   = mask_we ? mask_wdata : mask_q;
        dispatch = 1'b0;

        case (state_q)
            IDLE: begin
                if (int_rdy && !halt && int_en && found) begin
                    dispatch = 1'b1;
                    req_d    = 1'b1;
                    num_d    = {12'd0, win_idx};
                    insrv_d  = win_oh;
                    state_d  = WAIT_SRV;
                end
            end
            WAIT_SRV: begin
                if (int_srv_req) begin
                    state_d = WAIT_DONE;
                    if (int_srv_num != num_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (!int_srv_req) begin
                    insrv_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge always survives any clear landing in the same cycle.
        pend_d = (pend_q & ~((pend_clr_we ? pend_clr_data : 16'd0) |
                             (dispatch ? win_oh : 16'd0))) | irq_edge;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            num_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            insrv_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            num_q   <= num_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            insrv_q <= insrv_d;
            err_q   <= err_d;
        end
    end

    assign int_req    = req_q;
    assign int_num    = num_q;
    assign pending    = pend_q;
    assign mask       = mask_q;
    assign in_service = insrv_q;
    assign srv_err    = err_q;

endmodule

// File: tb/tb_ext_int_cont.sv
// Directed bench for ext_int_cont with two-stage synchronisers: latency,
// priority, masking, blocking, mismatch flag, clear/edge collision and reset.
module tb_ext_int_cont;

    logic        clk;
    logic        reset_b;
    logic [15:0] irq;
    logic        int_en;
    logic        halt;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic        pend_clr_we;
    logic [15:0] pend_clr_data;
    logic        int_rdy;
    logic        int_srv_req;
    logic [15:0] int_srv_num;
    logic        int_req;
    logic [15:0] int_num;
    logic [15:0] pending;
    logic [15:0] mask;
    logic [15:0] in_service;
    logic        srv_err;

    int n_checks = 0;
    int n_pass   = 0;

    ext_int_cont #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .irq           (irq),
        .int_en        (int_en),
        .halt          (halt),
        .mask_we       (mask_we),
        .mask_wdata    (mask_wdata),
        .pend_clr_we   (pend_clr_we),
        .pend_clr_data (pend_clr_data),
        .int_rdy       (int_rdy),
        .int_srv_req   (int_srv_req),
        .int_srv_num   (int_srv_num),
        .int_req       (int_req),
        .int_num       (int_num),
        .pending       (pending),
        .mask          (mask),
        .in_service    (in_service),
        .srv_err       (srv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [15:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_irq(input logic [15:0] v);
        irq = v;
        tick();
        tick();
        irq = '0;
    endtask

    task automatic serve(input logic [15:0] n);
        int_srv_req = 1'b1;
        int_srv_num = n;
        tick();
        int_srv_req = 1'b0;
        tick();
    endtask

    task automatic wait_req(output logic found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (int_req === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0; irq = '0; int_en = 1'b1; halt = 1'b0;
        mask_we = 1'b0; mask_wdata = '0; pend_clr_we = 1'b0; pend_clr_data = '0;
        int_rdy = 1'b1; int_srv_req = 1'b0; int_srv_num = '0;
        tick(); tick();
        n_checks++;
        if ({int_req, int_num, pending, mask, in_service, srv_err} !== 66'd0)
            $display("FAIL reset_state: got req=%b num=%h pend=%h mask=%h insrv=%h err=%b, want all 0",
                     int_req, int_num, pending, mask, in_service, srv_err);
        else n_pass++;
        reset_b = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write_mask(16'h0001);
        irq = 16'h0001;
        tick();                 // edge N
        tick();                 // N+1
        irq = '0;
        tick();                 // N+2: pending set
        n_checks++;
        if (pending !== 16'h0001 || int_req !== 1'b0)
            $display("FAIL single_pend: got pend=%h req=%b, want pend=0001 req=0", pending, int_req);
        else n_pass++;
        tick();                 // N+3: request issued
        n_checks++;
        if (int_req !== 1'b1 || int_num !== 16'h0000 || in_service !== 16'h0001 || pending !== 16'h0000)
            $display("FAIL single_dispatch: got req=%b num=%h insrv=%h pend=%h, want 1/0000/0001/0000",
                     int_req, int_num, in_service, pending);
        else n_pass++;
        tick();
        n_checks++;
        if (int_req !== 1'b0)
            $display("FAIL single_one_cycle: got req=%b, want 0", int_req);
        else n_pass++;
        int_srv_req = 1'b1; int_srv_num = 16'h0000;
        tick();
        n_checks++;
        if (in_service !== 16'h0001)
            $display("FAIL single_in_service: got %h, want 0001", in_service);
        else n_pass++;
        int_srv_req = 1'b0;
        tick();
        n_checks++;
        if (in_service !== 16'h0000 || srv_err !== 1'b0)
            $display("FAIL single_done: got insrv=%h err=%b, want 0000/0", in_service, srv_err);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic found;
        write_mask(16'hFFFF);
        pulse_irq(16'h0024);
        wait_req(found);
        n_checks++;
        if (!found || int_num !== 16'h0002 || pending !== 16'h0020)
            $display("FAIL prio_first: got found=%b num=%h pend=%h, want 1/0002/0020", found, int_num, pending);
        else n_pass++;
        serve(16'h0002);
        n_checks++;
        if (int_req !== 1'b0 || in_service !== 16'h0000)
            $display("FAIL prio_gap: got req=%b insrv=%h, want 0/0000", int_req, in_service);
        else n_pass++;
        tick();
        n_checks++;
        if (int_req !== 1'b1 || int_num !== 16'h0005 || in_service !== 16'h0020 || pending !== 16'h0000)
            $display("FAIL prio_second: got req=%b num=%h insrv=%h pend=%h, want 1/0005/0020/0000",
                     int_req, int_num, in_service, pending);
        else n_pass++;
        serve(16'h0005);
    endtask

    task automatic test_mask();
        logic seen;
        seen = 1'b0;
        write_mask(16'h0000);
        pulse_irq(16'h0080);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (int_req === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || pending !== 16'h0080)
            $display("FAIL mask_block: got seen=%b pend=%h, want 0/0080", seen, pending);
        else n_pass++;
        write_mask(16'h0080);
        n_checks++;
        if (int_req !== 1'b0 || mask !== 16'h0080)
            $display("FAIL mask_load: got req=%b mask=%h, want 0/0080", int_req, mask);
        else n_pass++;
        tick();
        n_checks++;
        if (int_req !== 1'b1 || int_num !== 16'h0007)
            $display("FAIL mask_dispatch: got req=%b num=%h, want 1/0007", int_req, int_num);
        else n_pass++;
        serve(16'h0007);
    endtask

    task automatic test_blocking();
        logic seen;
        write_mask(16'hFFFF);
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            if (k == 0) halt = 1'b1; else int_rdy = 1'b0;
            pulse_irq(k == 0 ? 16'h0002 : 16'h0200);
            for (int i = 0; i < 6; i++) begin
                tick();
                if (int_req === 1'b1) seen = 1'b1;
            end
            n_checks++;
            if (seen !== 1'b0 || pending !== (k == 0 ? 16'h0002 : 16'h0200))
                $display("FAIL block_hold_%0d: got seen=%b pend=%h", k, seen, pending);
            else n_pass++;
            halt = 1'b0; int_rdy = 1'b1;
            tick();
            n_checks++;
            if (int_req !== 1'b1 || int_num !== (k == 0 ? 16'h0001 : 16'h0009))
                $display("FAIL block_release_%0d: got req=%b num=%h", k, int_req, int_num);
            else n_pass++;
            serve(int_num);
        end
    endtask

    task automatic test_mismatch();
        logic found;
        pulse_irq(16'h0008);
        wait_req(found);
        n_checks++;
        if (!found || int_num !== 16'h0003)
            $display("FAIL mism_dispatch: got found=%b num=%h, want 1/0003", found, int_num);
        else n_pass++;
        int_srv_req = 1'b1; int_srv_num = 16'h0004;
        tick();
        n_checks++;
        if (srv_err !== 1'b1)
            $display("FAIL mism_set: got err=%b, want 1", srv_err);
        else n_pass++;
        int_srv_req = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (srv_err !== 1'b1 || in_service !== 16'h0000)
            $display("FAIL mism_sticky: got err=%b insrv=%h, want 1/0000", srv_err, in_service);
        else n_pass++;
    endtask

    task automatic test_clr_edge();
        write_mask(16'h0000);
        pulse_irq(16'h0400);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (pending !== 16'h0400)
            $display("FAIL clr_setup: got pend=%h, want 0400", pending);
        else n_pass++;
        irq = 16'h0400;
        tick();
        tick();
        pend_clr_we = 1'b1; pend_clr_data = 16'h0400;
        tick();                 // edge and clear land together
        pend_clr_we = 1'b0;
        irq = '0;
        n_checks++;
        if (pending !== 16'h0400)
            $display("FAIL clr_edge_wins: got pend=%h, want 0400", pending);
        else n_pass++;
        for (int i = 0; i < 4; i++) tick();
        pend_clr_we = 1'b1;
        tick();
        pend_clr_we = 1'b0;
        n_checks++;
        if (pending !== 16'h0000 || srv_err !== 1'b1)
            $display("FAIL clr_plain: got pend=%h err=%b, want 0000/1", pending, srv_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic found;
        logic seen;
        seen = 1'b0;
        write_mask(16'hFFFF);
        pulse_irq(16'h0010);
        wait_req(found);
        int_srv_req = 1'b1; int_srv_num = 16'h0004;
        tick();
        pulse_irq(16'h0040);
        tick(); tick();
        n_checks++;
        if (!found || int_num !== 16'h0004 || in_service !== 16'h0010 || pending !== 16'h0040)
            $display("FAIL rst_setup: got found=%b num=%h insrv=%h pend=%h, want 1/0004/0010/0040",
                     found, int_num, in_service, pending);
        else n_pass++;
        irq = 16'h0100;
        reset_b = 1'b0;
        #1;
        n_checks++;
        if ({int_req, int_num, pending, mask, in_service, srv_err} !== 66'd0)
            $display("FAIL rst_immediate: got req=%b num=%h pend=%h mask=%h insrv=%h err=%b, want all 0",
                     int_req, int_num, pending, mask, in_service, srv_err);
        else n_pass++;
        int_srv_req = 1'b0;
        tick(); tick();
        reset_b = 1'b1;
        tick(); tick();
        n_checks++;
        if (pending !== 16'h0000)
            $display("FAIL rst_held_early: got pend=%h, want 0000", pending);
        else n_pass++;
        tick();
        n_checks++;
        if (pending !== 16'h0100)
            $display("FAIL rst_held_edge: got pend=%h, want 0100", pending);
        else n_pass++;
        pend_clr_we = 1'b1; pend_clr_data = 16'h0100;
        tick();
        pend_clr_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (int_req === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (pending !== 16'h0000 || seen !== 1'b0 || in_service !== 16'h0000)
            $display("FAIL rst_quiet: got pend=%h seen=%b insrv=%h, want 0000/0/0000", pending, seen, in_service);
        else n_pass++;
        irq = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_blocking();
        test_mismatch();
        test_clr_edge();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
